// File: rtl/audio_frame_sequencer_if.sv
// rtl/audio_frame_sequencer_if.sv - register-file / sequencer / generator signal bundle
//
// Ports (signals):
//   NR52            master control, bit 7 = power
//   trigger         per-channel NRx4 bit-7 write pulse
//   length_enable   per-channel NRx4 bit-6 level
//   length_load     per-channel NRx1 write pulse
//   length_ch1/2/4  6-bit length load values
//   length_ch3      8-bit length load value
//   length_tick     256 Hz one-cycle enable
//   sweep_tick      128 Hz one-cycle enable
//   envelope_tick   64 Hz one-cycle enable
//   step            current sequencer step
//   channel_active  per-channel on flags
// master: register-file / generator side; slave: the sequencer.

interface audio_frame_sequencer_if;
    logic [7:0] NR52;
    logic [3:0] trigger;
    logic [3:0] length_enable;
    logic [3:0] length_load;
    logic [5:0] length_ch1;
    logic [5:0] length_ch2;
    logic [7:0] length_ch3;
    logic [5:0] length_ch4;
    logic       length_tick;
    logic       sweep_tick;
    logic       envelope_tick;
    logic [2:0] step;
    logic [3:0] channel_active;

    modport master (
        output NR52, trigger, length_enable, length_load,
               length_ch1, length_ch2, length_ch3, length_ch4,
        input  length_tick, sweep_tick, envelope_tick, step, channel_active
    );

    modport slave (
        input  NR52, trigger, length_enable, length_load,
               length_ch1, length_ch2, length_ch3, length_ch4,
        output length_tick, sweep_tick, envelope_tick, step, channel_active
    );
endinterface

// File: rtl/audio_frame_sequencer.sv
// rtl/audio_frame_sequencer.sv - frame sequencer ticks and channel length counters
//
// Ports:
//   system_clock  sole clock
//   reset_n       asynchronous active-low reset
//   bus           audio_frame_sequencer_if.slave (register inputs, tick/step/active outputs)

module audio_frame_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 512
) (
    input  logic                     system_clock,
    input  logic                     reset_n,
    audio_frame_sequencer_if.slave   bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic          power;
    logic [PW-1:0] presc;
    logic          wrap;
    logic [2:0]    step_q;
    logic          length_tick_q;
    logic          sweep_tick_q;
    logic          envelope_tick_q;

    logic [6:0]    rem1, rem2, rem4;
    logic [8:0]    rem3;
    logic [6:0]    rem1_n, rem2_n, rem4_n;
    logic [8:0]    rem3_n;
    logic [3:0]    active, active_n;
    logic [3:0]    dec;

    wire unused_nr52 = ^bus.NR52[6:0];

    assign power = bus.NR52[7];
    assign wrap  = (presc == PRESC_LAST);

    // Load value first, then trigger's zero-check on the (possibly loaded) value;
    // the decrement only happens when neither trigger nor load is present.
    function automatic logic [6:0] rem7_next(input logic [6:0] rem, input logic [5:0] value,
                                             input logic trig, input logic load, input logic dc);
        logic [6:0] r;
        r = load ? (7'd64 - {1'b0, value}) : rem;
        if (trig) begin
            if (r == 7'd0) r = 7'd64;
        end else if (!load && dc && rem != 7'd0) begin
            r = rem - 7'd1;
        end
        return r;
    endfunction

    // 256 - value in 9 bits: value 0 loads the full 256.
    function automatic logic [8:0] rem9_next(input logic [8:0] rem, input logic [7:0] value,
                                             input logic trig, input logic load, input logic dc);
        logic [8:0] r;
        r = load ? (9'd256 - {1'b0, value}) : rem;
        if (trig) begin
            if (r == 9'd0) r = 9'd256;
        end else if (!load && dc && rem != 9'd0) begin
            r = rem - 9'd1;
        end
        return r;
    endfunction

    function automatic logic active_next(input logic act, input logic trig, input logic load,
                                         input logic dc, input logic rem_one);
        logic a;
        a = act;
        if (trig)
            a = 1'b1;
        else if (!load && dc && rem_one)
            a = 1'b0;
        return a;
    endfunction

    // Prescaler, step counter and tick decode; decode uses the pre-increment step.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            presc           <= '0;
            step_q          <= 3'd0;
            length_tick_q   <= 1'b0;
            sweep_tick_q    <= 1'b0;
            envelope_tick_q <= 1'b0;
        end else if (!power) begin
            presc           <= '0;
            step_q          <= 3'd0;
            length_tick_q   <= 1'b0;
            sweep_tick_q    <= 1'b0;
            envelope_tick_q <= 1'b0;
        end else begin
            presc           <= wrap ? '0 : presc + 1'b1;
            length_tick_q   <= wrap && !step_q[0];
            sweep_tick_q    <= wrap && (step_q[1:0] == 2'b10);
            envelope_tick_q <= wrap && (step_q == 3'd7);
            if (wrap)
                step_q <= step_q + 3'd1;
        end
    end

    // Decrement acts on the edge that closes the registered length_tick cycle.
    always_comb begin
        dec      = {4{length_tick_q}} & bus.length_enable;
        rem1_n   = rem7_next(rem1, bus.length_ch1, bus.trigger[0], bus.length_load[0], dec[0]);
        rem2_n   = rem7_next(rem2, bus.length_ch2, bus.trigger[1], bus.length_load[1], dec[1]);
        rem3_n   = rem9_next(rem3, bus.length_ch3, bus.trigger[2], bus.length_load[2], dec[2]);
        rem4_n   = rem7_next(rem4, bus.length_ch4, bus.trigger[3], bus.length_load[3], dec[3]);
        active_n = active;
        active_n[0] = active_next(active[0], bus.trigger[0], bus.length_load[0], dec[0], rem1 == 7'd1);
        active_n[1] = active_next(active[1], bus.trigger[1], bus.length_load[1], dec[1], rem2 == 7'd1);
        active_n[2] = active_next(active[2], bus.trigger[2], bus.length_load[2], dec[2], rem3 == 9'd1);
        active_n[3] = active_next(active[3], bus.trigger[3], bus.length_load[3], dec[3], rem4 == 7'd1);
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            rem1   <= 7'd0;
            rem2   <= 7'd0;
            rem3   <= 9'd0;
            rem4   <= 7'd0;
            active <= 4'd0;
        end else if (!power) begin
            rem1   <= 7'd0;
            rem2   <= 7'd0;
            rem3   <= 9'd0;
            rem4   <= 7'd0;
            active <= 4'd0;
        end else begin
            rem1   <= rem1_n;
            rem2   <= rem2_n;
            rem3   <= rem3_n;
            rem4   <= rem4_n;
            active <= active_n;
        end
    end

    assign bus.length_tick    = length_tick_q;
    assign bus.sweep_tick     = sweep_tick_q;
    assign bus.envelope_tick  = envelope_tick_q;
    assign bus.step           = step_q;
    assign bus.channel_active = active;

endmodule
